bec_ladder_ctrl: RTL

Parametrised controller for the binary-Edwards-curve Montgomery ladder. It replaces the per-bit step sequencer with a block that runs a full scalar multiplication. On a `start` handshake it captures a KEY_W-bit scalar and the initial projective points, then drives an external multiply/accumulate unit (ACB) through seven micro-ops per key bit, MSB first. It pulses `done` once with the result held on `wout`/`zout`. The block sits between the point-arithmetic datapath (the ACB instance, field width M) and the top-level register interface.

---
 rtl/bec_pkg.sv | 24 ++
 rtl/bec_ladder_opdec.sv | 47 ++++
 rtl/bec_ladder_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bec_pkg.sv
// Shared types and constants for the binary-Edwards-curve ladder controller.
package bec_pkg;
  localparam int M_DEF     = 163;
  localparam int KEY_W_DEF = 163;
  localparam int NUM_OPS   = 7;

  localparam logic ACB_CFG_MUL = 1'b0;
  localparam logic ACB_CFG_MAC = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  typedef logic [2:0] op_t;

  // Operand source: a working register (idx 0..3 = A..D), the X^Z of the
  // pair starting at idx, or one of the curve constants.
  typedef enum logic [1:0] {SRC_REG, SRC_PAIR_XOR, SRC_INV_W0, SRC_D} src_kind_e;
  typedef struct packed {
    src_kind_e  kind;
    logic [1:0] idx;
  } src_t;

  // Per-register write-back: XPART means Z <= X_of_same_pair ^ r.
  typedef enum logic [1:0] {WB_NONE, WB_SET, WB_XOR, WB_XPART} wb_e;
endpackage

// File: rtl/bec_ladder_opdec.sv
// Micro-op decoder: maps (op, key bit) to physical operand selects,
// ACB mode and per-register write-back actions.
module bec_ladder_opdec
  import bec_pkg::*;
(
  input  op_t        op,
  input  logic       ki,
  output src_t       src_a,
  output src_t       src_b,
  output logic       cfg,
  output wb_e  [3:0] wb
);
  logic [1:0] xw, zw, xo, zo;

  // ki=1 works on (A,B) against (C,D); ki=0 swaps the roles.
  assign xw = ki ? 2'd0 : 2'd2;
  assign zw = xw | 2'd1;
  assign xo = ki ? 2'd2 : 2'd0;
  assign zo = xo | 2'd1;

  always_comb begin
    src_a = '{kind: SRC_REG, idx: xw};
    src_b = '{kind: SRC_REG, idx: zo};
    cfg   = ACB_CFG_MUL;
    for (int i = 0; i < 4; i++) wb[i] = WB_NONE;
    case (op)
      3'd0: wb[xw] = WB_SET;
      3'd1: begin src_a.idx = zw; src_b.idx = xo; wb[xw] = WB_XOR; end
      3'd2: begin src_a.idx = zw; wb[zw] = WB_SET; end
      3'd3: begin
        src_a.kind = SRC_INV_W0;
        src_b.idx  = xw;
        cfg        = ACB_CFG_MAC;
        wb[xw]     = WB_XOR;
        wb[zw]     = WB_XOR;
      end
      3'd4: begin
        src_a.idx = xo;
        src_b     = '{kind: SRC_PAIR_XOR, idx: xo};
        wb[xo]    = WB_SET;
      end
      3'd5: begin src_a.idx = zo; wb[zo] = WB_SET; end
      3'd6: begin src_a.kind = SRC_D; cfg = ACB_CFG_MAC; wb[zo] = WB_XPART; end
      default: ;
    endcase
  end
endmodule

// File: rtl/bec_ladder_ctrl.sv
// Full Montgomery-ladder scalar multiplication sequencer driving an external
// multiply/accumulate unit, seven micro-ops per key bit, MSB first.
module bec_ladder_ctrl
  import bec_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int KEY_W = KEY_W_DEF,
  parameter int IW    = $clog2(KEY_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key,
  input  logic [M-1:0]     w1,
  input  logic [M-1:0]     z1,
  input  logic [M-1:0]     w2,
  input  logic [M-1:0]     z2,
  input  logic [M-1:0]     d,
  input  logic [M-1:0]     inv_w0,
  output logic             acb_start,
  output logic             acb_cfg,
  output logic [M-1:0]     acb_a,
  output logic [M-1:0]     acb_b,
  input  logic [M-1:0]     acb_c,
  input  logic             acb_done,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    bit_idx,
  output logic [M-1:0]     wout,
  output logic [M-1:0]     zout
);
  state_e            state, state_d;
  logic [3:0][M-1:0] regs;   // A, B, C, D
  logic [KEY_W-1:0]  key_q;
  op_t               op;
  src_t              src_a, src_b;
  logic              cfg;
  wb_e  [3:0]        wb;
  logic              active, last_op, last_bit, wb_en;

  bec_ladder_opdec u_opdec (
    .op    (op),
    .ki    (key_q[KEY_W-1]),
    .src_a (src_a),
    .src_b (src_b),
    .cfg   (cfg),
    .wb    (wb)
  );

  function automatic logic [M-1:0] pick(input src_t s, input logic [3:0][M-1:0] r,
                                        input logic [M-1:0] dc, input logic [M-1:0] iw);
    case (s.kind)
      SRC_REG:      pick = r[s.idx];
      SRC_PAIR_XOR: pick = r[s.idx] ^ r[s.idx | 2'd1];
      SRC_INV_W0:   pick = iw;
      default:      pick = dc;
    endcase
  endfunction

  // Operands are decoded from stable registers, so they hold through WAIT.
  assign active    = (state == S_ISSUE) || (state == S_WAIT);
  assign acb_start = (state == S_ISSUE);
  assign acb_cfg   = active & cfg;
  assign acb_a     = active ? pick(src_a, regs, d, inv_w0) : '0;
  assign acb_b     = active ? pick(src_b, regs, d, inv_w0) : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign wout      = regs[0];
  assign zout      = regs[1];
  assign last_op   = (op == op_t'(NUM_OPS - 1));
  assign last_bit  = (bit_idx == '0);
  assign wb_en     = (state == S_WAIT) && acb_done && !abort;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort)         state_d = S_IDLE;
        else if (acb_done) state_d = (last_op && last_bit) ? S_DONE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs    <= '0;
      key_q   <= '0;
      op      <= '0;
      bit_idx <= '0;
    end else if (state == S_IDLE && start) begin
      regs    <= {z2, w2, z1, w1};
      key_q   <= key;
      op      <= '0;
      bit_idx <= IW'(KEY_W - 1);
    end else if (wb_en) begin
      for (int i = 0; i < 4; i++) begin
        case (wb[i])
          WB_SET:   regs[i] <= acb_c;
          WB_XOR:   regs[i] <= regs[i] ^ acb_c;
          WB_XPART: regs[i] <= regs[i & 2] ^ acb_c;
          default:  ;
        endcase
      end
      if (!last_op) begin
        op <= op + 3'd1;
      end else if (!last_bit) begin
        op      <= '0;
        bit_idx <= bit_idx - IW'(1);
        key_q   <= key_q << 1;
      end
    end
  end
endmodule
